expr_tx: RTL and testbench
==========================

# expr_tx

Transmitter for the expression character stream: it serialises a loaded job of decimal digits and operators into ASCII characters of the form digit (op digit)*, one character per handshake. It sits on the source side of the per-cycle character interface that the expression recogniser consumes. A well-formed job always produces a stream the recogniser accepts after its final character.

## Interface
- MAX_TERMS, 8, maximum number of digit terms per job (operators = MAX_TERMS-1)
- TW, 4, width of term-count field; must hold MAX_TERMS
- clk  input  1  sole clock, rising edge
- clr  input  1  synchronous, active-high reset
- start  input  1  job request pulse; sampled only when busy=0
- in_terms  input  TW  number of digit terms, legal range 1..MAX_TERMS
- in_digits  input  4*MAX_TERMS  BCD digits; term i in bits [4i+3:4i], term 0 sent first
- in_ops  input  MAX_TERMS-1  operator after term i: 0 = '+' (8'h2B), 1 = '*' (8'h2A)
- out_char  output  8  ASCII character
- out_valid  output  1  out_char valid
- out_ready  input  1  sink accepts out_char this cycle
- out_last  output  1  out_char is final character of job
- busy  output  1  job in progress
- done  output  1  one-cycle pulse after final handshake
- err  output  1  one-cycle pulse when start is rejected

## Operation
- Reset values (clr=1 at edge): out_char=8'h00, out_valid=0, out_last=0, busy=0, done=0, err=0, state=IDLE.
- States: IDLE, DIG, OP, FIN.
- IDLE: on start with legal job (1<=in_terms<=MAX_TERMS, every digit of terms 0..in_terms-1 <=9) latch in_digits, in_ops, in_terms; index=0; go DIG; busy=1. Illegal job: err=1 for one cycle, stay IDLE, nothing latched. Digits above in_terms-1 are ignored.
- DIG: out_char = 8'h30 + digit[index]; out_valid=1; out_last = (index==terms-1). On handshake: if last go FIN, else go OP.
- OP: out_char = op[index] ? 8'h2A : 8'h2B; out_valid=1, out_last=0. On handshake: index+1, go DIG.
- FIN: out_valid=0, done=1 for this one cycle, busy=0, go IDLE.
- Handshake = out_valid & out_ready. Without handshake out_char/out_last/out_valid held stable.
- Character count per job = 2*terms-1.
- start while busy=1 ignored, no err.
- Latched job registers isolate inputs: in_* may change freely after acceptance.

## Timing
- start accepted at edge N -> first character valid in cycle N+1.
- With out_ready held 1: one character per cycle; last character cycle L, done high in cycle L+1, busy=0 in L+1, new start accepted at edge ending L+1, next job first char in L+2.
- err asserted in cycle after rejecting edge, one cycle only.
- out_ready low stalls indefinitely; no timeout.
- clr mid-job: at that edge all outputs return to reset values, job discarded, no done.
- clr and start same cycle: clr wins, start ignored.
- done and err never both high.

## Structure
- Shared header expr_defs.vh: ASCII constants CH_0 (8'h30), CH_PLUS (8'h2B), CH_MUL (8'h2A); state encodings for IDLE/DIG/OP/FIN. Recogniser and transmitter share the ASCII constants.
- Single module; no sub-module. Outputs registered (Moore), driven from state and latched job.

## Test plan
- terms=3, digits {7,0,4}(term0=4? no: term0=7, term1=0, term2=4), ops {1,0}, out_ready=1 -> "7","*","0","+","4" on 5 consecutive cycles, out_last only on "4", done next cycle.
- terms=1, digit0=9 -> single char 8'h39 with out_last=1, done following cycle; stream accepted by recogniser (its out=1).
- terms=2, out_ready toggling 1,0,0,1,1 -> each char held stable while ready=0; exactly 3 chars "d op d", no duplicates or skips.
- Rejections: terms=0; terms=9 (MAX_TERMS=8); terms=2 with digit1=4'hA -> err one cycle, busy stays 0, out_valid stays 0.
- clr asserted on second character of a 5-char job -> next cycle all outputs 0, no done; fresh start then produces full correct stream.
- start pulsed again during busy -> ignored; back-to-back jobs at full rate give 1 idle cycle (done) between streams.

Source files
------------

// File: rtl/expr_tx_pkg.sv
// ---------------------------------------------------------------------------
// expr_tx_pkg
//   Shared definitions for the expression character stream: the ASCII codes
//   exchanged between transmitter and recogniser, the transmitter state
//   encoding, and small helpers that map job fields onto characters.
// ---------------------------------------------------------------------------
package expr_tx_pkg;

    localparam logic [7:0] CH_0    = 8'h30;  // '0'
    localparam logic [7:0] CH_PLUS = 8'h2B;  // '+'
    localparam logic [7:0] CH_MUL  = 8'h2A;  // '*'

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIG  = 2'd1,
        S_OP   = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    // BCD digit (already known to be 0..9) to its ASCII character.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return CH_0 + {4'h0, d};
    endfunction

    // Operator bit to its ASCII character: 1 = '*', 0 = '+'.
    function automatic logic [7:0] op_char(input logic is_mul);
        return is_mul ? CH_MUL : CH_PLUS;
    endfunction

endpackage

// File: rtl/expr_tx.sv
// ---------------------------------------------------------------------------
// expr_tx
//   Serialises a loaded job of BCD digits and operators into the ASCII
//   stream  digit (op digit)*  using a valid/ready handshake, one character
//   per accepted transfer.
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   synchronous active-high reset
//   start      in   job request, only looked at while busy = 0
//   in_terms   in   number of digit terms (legal 1..MAX_TERMS)
//   in_digits  in   BCD digits, term i at [4i+3:4i], term 0 sent first
//   in_ops     in   operator after term i: 0 = '+', 1 = '*'
//   out_char   out  ASCII character
//   out_valid  out  out_char is valid
//   out_ready  in   sink takes out_char this cycle
//   out_last   out  out_char is the final character of the job
//   busy       out  job in progress
//   done       out  one-cycle pulse after the final handshake
//   err        out  one-cycle pulse after a rejected start
//
// All outputs are decoded only from registered state and the latched job,
// so they never depend combinationally on any input.
// ---------------------------------------------------------------------------
module expr_tx
    import expr_tx_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int TW        = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [TW-1:0]          in_terms,
    input  logic [4*MAX_TERMS-1:0] in_digits,
    input  logic [MAX_TERMS-2:0]   in_ops,
    output logic [7:0]             out_char,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int            IW          = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
    localparam logic [TW-1:0] MAX_TERMS_W = TW'(MAX_TERMS);

    state_e                 state_q, state_d;
    logic                   err_q, err_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TW-1:0]          terms_q, terms_d;
    logic [4*MAX_TERMS-1:0] digits_q, digits_d;
    // One spare top bit so an index into the operators never leaves the vector.
    logic [MAX_TERMS-1:0]   ops_q, ops_d;

    logic                   job_legal;
    logic                   is_last;

    // Current digit is the final term of the job.
    assign is_last = (TW'(idx_q) == (terms_q - 1'b1));

    // A job is legal when its term count is in range and every digit that
    // will actually be sent is BCD; digits beyond the term count are ignored.
    always_comb begin
        job_legal = (in_terms != '0) && (in_terms <= MAX_TERMS_W);
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((TW'(i) < in_terms) && (in_digits[4*i +: 4] > 4'd9)) begin
                job_legal = 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        err_d    = 1'b0;
        idx_d    = idx_q;
        terms_d  = terms_q;
        digits_d = digits_q;
        ops_d    = ops_q;

        unique case (state_q)
            // FIN also has busy = 0, so it takes a new start exactly like
            // IDLE; that is what allows back-to-back jobs with one gap cycle.
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start) begin
                    if (job_legal) begin
                        terms_d  = in_terms;
                        digits_d = in_digits;
                        ops_d    = {1'b0, in_ops};
                        idx_d    = '0;
                        state_d  = S_DIG;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DIG: begin
                if (out_ready) begin
                    state_d = is_last ? S_FIN : S_OP;
                end
            end
            S_OP: begin
                if (out_ready) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_DIG;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: the only registers that need a reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (clr) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the latched job is deliberately left out of reset; it is only
    // read while in DIG/OP, which can only be reached by loading it first.
    always_ff @(posedge clk) begin
        idx_q    <= idx_d;
        terms_q  <= terms_d;
        digits_q <= digits_d;
        ops_q    <= ops_d;
    end

    // Moore output decode.
    always_comb begin
        out_char  = 8'h00;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_DIG: begin
                out_char  = digit_char(digits_q[{idx_q, 2'b00} +: 4]);
                out_valid = 1'b1;
                out_last  = is_last;
                busy      = 1'b1;
            end
            S_OP: begin
                out_char  = op_char(ops_q[idx_q]);
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_expr_tx.sv
// ---------------------------------------------------------------------------
// tb_expr_tx
//   Self-checking bench for expr_tx. Expected characters come from a queue
//   built directly from the job (digit, operator, digit, ...); outputs are
//   sampled on the falling edge, inputs are driven right after sampling.
// ---------------------------------------------------------------------------
module tb_expr_tx;

    localparam int MAX_TERMS = 8;
    localparam int TW        = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [3:0]  in_terms;
    logic [31:0] in_digits;
    logic [6:0]  in_ops;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] rdy_pat;

    expr_tx #(.MAX_TERMS(MAX_TERMS), .TW(TW)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .in_terms  (in_terms),
        .in_digits (in_digits),
        .in_ops    (in_ops),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_char"},  32'(out_char),  32'h00);
        check({tag, "_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_last"},  32'(out_last),  32'h0);
        check({tag, "_busy"},  32'(busy),      32'h0);
        check({tag, "_done"},  32'(done),      32'h0);
        check({tag, "_err"},   32'(err),       32'h0);
    endtask

    // Runs one legal job from a cycle where the DUT can accept a start.
    // mode: 0 = ready always 1, 1 = random ready, 2 = ready from rdy_pat.
    // poke: pulse random start requests while busy; they must be ignored.
    // Returns at the falling edge of the done cycle.
    task automatic run_job(input int terms, input logic [31:0] digits,
                           input logic [6:0] ops, input int mode, input bit poke);
        logic [7:0] q[$];
        int         k;
        bit         rdy;
        for (int i = 0; i < terms; i++) begin
            q.push_back(8'h30 + 8'(digits[4*i +: 4]));
            if (i < terms - 1) q.push_back(ops[i] ? 8'h2A : 8'h2B);
        end
        start     = 1'b1;
        in_terms  = 4'(terms);
        in_digits = digits;
        in_ops    = ops;
        @(negedge clk);
        // Scramble the inputs: the latched job must be what gets sent.
        start     = 1'b0;
        in_terms  = 4'($urandom);
        in_digits = $urandom;
        in_ops    = 7'($urandom);
        k = 0;
        while (q.size() > 0 && k < 200) begin
            check("char",  32'(out_char),  32'(q[0]));
            check("valid", 32'(out_valid), 32'h1);
            check("last",  32'(out_last),  32'(q.size() == 1));
            check("busy",  32'(busy),      32'h1);
            check("done",  32'(done),      32'h0);
            check("err",   32'(err),       32'h0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = rdy_pat[k % 16];
            endcase
            out_ready = rdy;
            if (poke && $urandom_range(0, 3) == 0) begin
                start     = 1'b1;
                in_terms  = 4'($urandom);
                in_digits = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (rdy) void'(q.pop_front());
            k++;
        end
        start = 1'b0;
        check("timeout",   32'(q.size()),  32'h0);
        check("fin_done",  32'(done),      32'h1);
        check("fin_busy",  32'(busy),      32'h0);
        check("fin_valid", 32'(out_valid), 32'h0);
        check("fin_err",   32'(err),       32'h0);
    endtask

    // Presents an illegal job from a cycle where the DUT can accept a start.
    task automatic reject_job(input logic [3:0] terms, input logic [31:0] digits);
        start     = 1'b1;
        in_terms  = terms;
        in_digits = digits;
        in_ops    = 7'($urandom);
        @(negedge clk);
        start = 1'b0;
        check("rej_err",   32'(err),       32'h1);
        check("rej_busy",  32'(busy),      32'h0);
        check("rej_valid", 32'(out_valid), 32'h0);
        check("rej_done",  32'(done),      32'h0);
        @(negedge clk);
        check("rej_err_clear", 32'(err),       32'h0);
        check("rej_busy2",     32'(busy),      32'h0);
        check("rej_valid2",    32'(out_valid), 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int          terms;
        logic [31:0] digits;
        logic [3:0]  d;
        int          pos;

        clr       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        in_terms  = '0;
        in_digits = '0;
        in_ops    = '0;
        rdy_pat   = '1;

        // Reset state.
        idle(2);
        check_quiet("reset");
        clr = 1'b0;
        idle(1);

        // "7*0+4" at full rate, done in the following cycle.
        run_job(3, 32'h0000_0407, 7'b0000001, 0, 1'b0);
        idle(1);

        // Single term: one character with out_last; upper digits are junk.
        run_job(1, 32'hFEDC_BA99, 7'($urandom), 0, 1'b0);
        idle(1);

        // Two terms with ready pattern 1,0,0,1,1: held while stalled.
        rdy_pat = 16'hFFF9;
        run_job(2, 32'hABCD_EF85, 7'b0000001, 2, 1'b0);
        rdy_pat = '1;
        out_ready = 1'b1;
        idle(1);

        // Rejections.
        reject_job(4'd0,  32'h0000_0000);
        reject_job(4'd9,  32'h0000_0000);
        reject_job(4'd15, 32'h1111_1111);
        reject_job(4'd2,  32'h0000_00A3);
        reject_job(4'd8,  32'hF999_9999);

        // Largest job.
        run_job(8, 32'h9999_9999, 7'h55, 1, 1'b0);
        out_ready = 1'b1;
        idle(1);

        // clr on the second character of a 5-character job.
        start     = 1'b1;
        in_terms  = 4'd3;
        in_digits = 32'h0000_0407;
        in_ops    = 7'b0000001;
        @(negedge clk);
        start = 1'b0;
        check("clr_c0", 32'(out_char), 32'h37);
        @(negedge clk);
        check("clr_c1", 32'(out_char), 32'h2A);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_quiet("clr_mid");
        @(negedge clk);
        check_quiet("clr_after");
        run_job(3, 32'h0000_0407, 7'b0000001, 0, 1'b0);
        idle(1);

        // clr and start in the same cycle: clr wins.
        clr       = 1'b1;
        start     = 1'b1;
        in_terms  = 4'd2;
        in_digits = 32'h0000_0012;
        @(negedge clk);
        clr   = 1'b0;
        start = 1'b0;
        check_quiet("clr_start");
        @(negedge clk);
        check_quiet("clr_start2");

        // Starts while busy are ignored; then back-to-back jobs.
        run_job(4, 32'h0000_5678, 7'b0000101, 1, 1'b1);
        out_ready = 1'b1;
        run_job(2, 32'h0000_0031, 7'b0000000, 0, 1'b0);
        run_job(3, 32'h0000_0962, 7'b0000011, 0, 1'b0);
        idle(1);

        // Randomised jobs, legal and illegal, with random gaps.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0: reject_job(4'd0, $urandom);
                    1: reject_job(4'($urandom_range(9, 15)), $urandom);
                    default: begin
                        terms  = $urandom_range(1, 8);
                        digits = 32'h0;
                        for (int i = 0; i < terms; i++) digits[4*i +: 4] = 4'($urandom_range(0, 9));
                        pos = $urandom_range(0, terms - 1);
                        d   = 4'($urandom_range(10, 15));
                        digits[4*pos +: 4] = d;
                        reject_job(4'(terms), digits);
                    end
                endcase
            end else begin
                terms = $urandom_range(1, 8);
                for (int i = 0; i < 8; i++) begin
                    if (i < terms) digits[4*i +: 4] = 4'($urandom_range(0, 9));
                    else           digits[4*i +: 4] = 4'($urandom_range(0, 15));
                end
                run_job(terms, digits, 7'($urandom), $urandom_range(0, 1),
                        1'($urandom_range(0, 1)));
                out_ready = 1'b1;
            end
            idle($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
